// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_os
//  Purpose  : Oversampling UART receiver. Fractional baud tick generator,
//             two-flop input synchroniser, 3-sample majority vote per bit,
//             configurable data/parity/stop format, false-start rejection,
//             per-frame error flags and a small first-word-fall-through FIFO
//             with a valid/ready output handshake.
//  Ports    : clk        - system clock, rising edge
//             rst_n      - asynchronous active-low reset
//             rx         - asynchronous serial line, idles high
//             rx_data    - data field of the FIFO head entry
//             rx_valid   - FIFO not empty
//             rx_ready   - consumer accepts head entry when rx_valid is high
//             frame_err  - head entry had a stop bit sampled low
//             parity_err - head entry failed its parity check
//             overrun    - one-clock pulse when a finished frame is dropped
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_os #(
    parameter int CLKFREQ    = 27000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam logic [31:0] C_INC  = 32'(BAUD * OVERSAMPLE);
    localparam logic [31:0] C_CLK  = 32'(CLKFREQ);
    localparam int          C_SW   = $clog2(OVERSAMPLE);
    localparam int          C_BW   = $clog2(DATA_BITS);
    localparam int          C_AW   = $clog2(FIFO_DEPTH);
    localparam int          C_EW   = DATA_BITS + 2;
    localparam logic [C_SW-1:0] C_S_LO  = C_SW'(OVERSAMPLE / 2 - 1);
    localparam logic [C_SW-1:0] C_S_MID = C_SW'(OVERSAMPLE / 2);
    localparam logic [C_SW-1:0] C_S_HI  = C_SW'(OVERSAMPLE / 2 + 1);
    localparam logic [C_SW-1:0] C_S_END = C_SW'(OVERSAMPLE - 1);
    localparam logic [C_BW-1:0] C_B_END = C_BW'(DATA_BITS - 1);
    localparam logic            C_STOP_LAST = 1'(STOP_BITS - 1);
    // Required XOR of data and parity bit: 1 for odd parity, 0 for even.
    localparam logic            C_PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and fractional tick generator
    // ------------------------------------------------------------------
    logic        rx_meta_q, rx_s_q;
    logic [31:0] acc_q, acc_d;
    logic [31:0] w_sum;
    logic        w_tick;

    assign w_sum  = acc_q + C_INC;
    assign w_tick = (w_sum >= C_CLK);
    assign acc_d  = w_tick ? (w_sum - C_CLK) : w_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            acc_q     <= '0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            acc_q     <= acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [C_SW-1:0]      scnt_q, scnt_d;
    logic [C_BW-1:0]      bcnt_q, bcnt_d;
    logic                 stopc_q, stopc_d;
    logic                 smp0_q, smp0_d;
    logic                 smp1_q, smp1_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;

    logic [C_SW-1:0]      w_scnt_nxt;
    logic                 w_vote;
    logic                 w_push;
    logic [C_EW-1:0]      w_push_entry;

    // scnt holds the index of the last tick processed inside the current bit.
    assign w_scnt_nxt = (scnt_q == C_S_END) ? '0 : scnt_q + 1'b1;
    // Third sample is the live synchronised line at the vote tick.
    assign w_vote = (smp0_q & smp1_q) | (smp0_q & rx_s_q) | (smp1_q & rx_s_q);
    // A low final stop-bit vote is folded into the entry being pushed.
    assign w_push_entry = {perr_q, ferr_q | ~w_vote, shift_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            scnt_q  <= '0;
            bcnt_q  <= '0;
            stopc_q <= 1'b0;
            smp0_q  <= 1'b0;
            smp1_q  <= 1'b0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            bcnt_q  <= bcnt_d;
            stopc_q <= stopc_d;
            smp0_q  <= smp0_d;
            smp1_q  <= smp1_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        bcnt_d  = bcnt_q;
        stopc_d = stopc_q;
        smp0_d  = smp0_q;
        smp1_d  = smp1_q;
        shift_d = shift_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        w_push  = 1'b0;

        if (w_tick) begin
            if (state_q == S_IDLE) begin
                // The detecting tick is sample 0 of the start bit.
                if (!rx_s_q) begin
                    state_d = S_START;
                    scnt_d  = '0;
                    bcnt_d  = '0;
                    stopc_d = 1'b0;
                    shift_d = '0;
                    ferr_d  = 1'b0;
                    perr_d  = 1'b0;
                end
            end else begin
                scnt_d = w_scnt_nxt;
                if (w_scnt_nxt == C_S_LO)  smp0_d = rx_s_q;
                if (w_scnt_nxt == C_S_MID) smp1_d = rx_s_q;

                case (state_q)
                    S_START: begin
                        if (w_scnt_nxt == C_S_HI && w_vote) begin
                            state_d = S_IDLE;
                        end else if (w_scnt_nxt == C_S_END) begin
                            state_d = S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (w_scnt_nxt == C_S_HI) begin
                            shift_d = {w_vote, shift_q[DATA_BITS-1:1]};
                        end
                        if (w_scnt_nxt == C_S_END) begin
                            if (bcnt_q == C_B_END) begin
                                bcnt_d  = '0;
                                state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                            end else begin
                                bcnt_d = bcnt_q + 1'b1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (w_scnt_nxt == C_S_HI) begin
                            if (((^shift_q) ^ w_vote) != C_PAR_ODD) perr_d = 1'b1;
                        end
                        if (w_scnt_nxt == C_S_END) state_d = S_STOP;
                    end
                    S_STOP: begin
                        if (w_scnt_nxt == C_S_HI) begin
                            if (!w_vote) ferr_d = 1'b1;
                            // Leave at mid-bit so the next start edge is not missed.
                            if (stopc_q == C_STOP_LAST) begin
                                w_push  = 1'b1;
                                state_d = S_IDLE;
                            end
                        end
                        if (w_scnt_nxt == C_S_END) stopc_d = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO: pointers carry one wrap bit to tell full from empty
    // ------------------------------------------------------------------
    logic [C_EW-1:0] mem_q [FIFO_DEPTH];
    logic [C_AW:0]   wptr_q, rptr_q;
    logic            overrun_q;
    logic            w_empty, w_full, w_pop, w_wr;

    assign w_empty = (wptr_q == rptr_q);
    assign w_full  = (wptr_q[C_AW] != rptr_q[C_AW]) &&
                     (wptr_q[C_AW-1:0] == rptr_q[C_AW-1:0]);
    assign w_pop   = !w_empty && rx_ready;
    // On a full FIFO a simultaneous pop frees the slot being written.
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            overrun_q <= w_push && w_full && !w_pop;
            if (w_wr) begin
                mem_q[wptr_q[C_AW-1:0]] <= w_push_entry;
                wptr_q <= wptr_q + 1'b1;
            end
            if (w_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    assign rx_valid = !w_empty;
    assign {parity_err, frame_err, rx_data} = mem_q[rptr_q[C_AW-1:0]];
    assign overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_os
//  Purpose  : Self-checking bench for uart_rx_os. Three receivers with
//             different formats; a frame-level scoreboard predicts every
//             popped entry and every dropped frame.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;

    localparam int NU = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NU-1:0] rx_l;
    logic [NU-1:0] rdy_l;
    logic [NU-1:0] val_l;
    logic [NU-1:0] ovr_l;
    logic [10:0]   ent [NU];

    logic [7:0] d0, d1;
    logic [6:0] d2;
    logic       fe0, pe0, fe1, pe1, fe2, pe2;

    always #5 clk = ~clk;

    // u0: 8N1, u1: 8E1, u2: 7O2 with a fractional baud divisor and depth 2
    uart_rx_os #(.CLKFREQ(3686400), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[0]), .rx_data(d0), .rx_valid(val_l[0]),
        .rx_ready(rdy_l[0]), .frame_err(fe0), .parity_err(pe0), .overrun(ovr_l[0]));
    uart_rx_os #(.CLKFREQ(3686400), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[1]), .rx_data(d1), .rx_valid(val_l[1]),
        .rx_ready(rdy_l[1]), .frame_err(fe1), .parity_err(pe1), .overrun(ovr_l[1]));
    uart_rx_os #(.CLKFREQ(27000000), .BAUD(115200), .OVERSAMPLE(8), .DATA_BITS(7),
                 .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[2]), .rx_data(d2), .rx_valid(val_l[2]),
        .rx_ready(rdy_l[2]), .frame_err(fe2), .parity_err(pe2), .overrun(ovr_l[2]));

    assign ent[0] = {pe0, fe0, 1'b0, d0};
    assign ent[1] = {pe1, fe1, 1'b0, d1};
    assign ent[2] = {pe2, fe2, 2'b00, d2};

    function automatic int bclk(input int u);
        return (u == 2) ? 234 : 32;
    endfunction
    function automatic int dbits(input int u);
        return (u == 2) ? 7 : 8;
    endfunction
    function automatic int par(input int u);
        case (u)
            0:       return 0;
            1:       return 2;
            default: return 1;
        endcase
    endfunction
    function automatic int stops(input int u);
        return (u == 2) ? 2 : 1;
    endfunction
    function automatic int depth(input int u);
        return (u == 2) ? 2 : 4;
    endfunction

    // Scoreboard: entries currently expected inside each DUT FIFO
    logic [10:0] q0[$], q1[$], q2[$];
    int          tests = 0, fails = 0;
    int          exp_ovr [NU];
    int          ovr_seen [NU];
    int          vcnt [NU];
    int          npop [NU];
    logic [10:0] last_pop [NU];
    logic [10:0] exp_e;

    function automatic int qsize(input int u);
        case (u)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_push(input int u, input logic [10:0] e);
        if (!rdy_l[u] && qsize(u) >= depth(u)) begin
            exp_ovr[u]++;
        end else begin
            case (u)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    // Inputs change 1 time unit after a rising edge
    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame. flip_par inverts the correct parity bit; stop_ok=0
    // drives every stop bit low and then idles the line for one bit.
    task automatic send(input int u, input logic [8:0] data_in, input bit flip_par,
                        input bit stop_ok, input bit track);
        logic [8:0]  data;
        logic        p;
        logic [10:0] e;
        data = data_in & ((9'h1 << dbits(u)) - 9'h1);
        e    = {1'b0, ~stop_ok, data};
        rx_l[u] = 1'b0;
        wclk(bclk(u));
        for (int i = 0; i < dbits(u); i++) begin
            rx_l[u] = data[i];
            wclk(bclk(u));
        end
        if (par(u) != 0) begin
            p = ^data;
            if (par(u) == 1) p = ~p;
            if (flip_par) begin
                p     = ~p;
                e[10] = 1'b1;
            end
            rx_l[u] = p;
            wclk(bclk(u));
        end
        for (int s = 0; s < stops(u); s++) begin
            if (s == stops(u) - 1 && track) model_push(u, e);
            rx_l[u] = stop_ok;
            wclk(bclk(u));
        end
        rx_l[u] = 1'b1;
        if (!stop_ok) wclk(bclk(u));
    endtask

    // Compare process: every accepted entry is checked against the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int u = 0; u < NU; u++) begin
                if (val_l[u]) vcnt[u]++;
                if (ovr_l[u]) ovr_seen[u]++;
                if (val_l[u] && rdy_l[u]) begin
                    npop[u]++;
                    last_pop[u] = ent[u];
                    if (qsize(u) == 0) begin
                        chk($sformatf("u%0d pop with nothing expected (entry %0h)", u, ent[u]),
                            qsize(u), 1);
                    end else begin
                        case (u)
                            0:       exp_e = q0.pop_front();
                            1:       exp_e = q1.pop_front();
                            default: exp_e = q2.pop_front();
                        endcase
                        chk($sformatf("u%0d popped entry", u), ent[u], exp_e);
                    end
                end
            end
        end
    end

    initial begin
        int np;
        int u;
        for (int i = 0; i < NU; i++) begin
            exp_ovr[i]  = 0;
            ovr_seen[i] = 0;
            vcnt[i]     = 0;
            npop[i]     = 0;
            last_pop[i] = '0;
        end
        rst_n = 1'b0;
        rx_l  = '1;
        rdy_l = '1;
        wclk(5);
        rst_n = 1'b1;
        wclk(1);

        // Reset state
        chk("reset rx_valid", val_l, 3'b000);
        chk("reset rx_data", {d0, d1, 1'b0, d2}, 24'h0);
        chk("reset error flags", {fe0, pe0, fe1, pe1, fe2, pe2}, 6'b0);
        chk("reset overrun", ovr_l, 3'b000);
        wclk(20);

        // Clean 8N1 byte
        vcnt[0] = 0;
        send(0, 9'h0A5, 1'b0, 1'b1, 1'b1);
        wclk(40);
        chk("clean valid cycles", vcnt[0], 1);
        chk("clean entry", last_pop[0], {2'b00, 9'h0A5});

        // Even parity: 0x3C has four ones, so a parity bit of 1 is wrong
        send(1, 9'h03C, 1'b1, 1'b1, 1'b1);
        wclk(40);
        chk("parity bad entry", last_pop[1], {2'b10, 9'h03C});
        send(1, 9'h03C, 1'b0, 1'b1, 1'b1);
        wclk(40);
        chk("parity good entry", last_pop[1], {2'b00, 9'h03C});

        // Framing error then recovery
        send(0, 9'h000, 1'b0, 1'b0, 1'b1);
        chk("framing error entry", last_pop[0], {2'b01, 9'h000});
        send(0, 9'h055, 1'b0, 1'b1, 1'b1);
        wclk(40);
        chk("recovery entry", last_pop[0], {2'b00, 9'h055});

        // Glitch rejection
        np = npop[0];
        rx_l[0] = 1'b0;
        wclk(8);
        rx_l[0] = 1'b1;
        wclk(60);
        chk("glitch no pop", npop[0], np);
        send(0, 9'h012, 1'b0, 1'b1, 1'b1);
        wclk(40);
        chk("after glitch entry", last_pop[0], {2'b00, 9'h012});

        // Overrun: fifth back-to-back frame is dropped
        rdy_l[0] = 1'b0;
        ovr_seen[0] = 0;
        np = npop[0];
        for (int i = 1; i <= 5; i++) send(0, 9'(i), 1'b0, 1'b1, 1'b1);
        wclk(40);
        chk("overrun pulses", ovr_seen[0], 1);
        chk("full fifo valid", val_l[0], 1);
        rdy_l[0] = 1'b1;
        wclk(10);
        chk("drain pops", npop[0] - np, 4);
        chk("drain last entry", last_pop[0], {2'b00, 9'h004});
        chk("drained valid", val_l[0], 0);

        // Reset during data bit 3 of an untracked frame
        fork
            send(0, 9'h0F8, 1'b0, 1'b1, 1'b0);
            begin
                wclk(4 * 32 + 10);
                rst_n = 1'b0;
                wclk(3);
                rst_n = 1'b1;
                wclk(1);
                chk("mid-frame reset valid", val_l[0], 0);
                chk("mid-frame reset data", d0, 8'h00);
            end
        join
        wclk(100);
        chk("no entry after reset", val_l[0], 0);
        send(0, 9'h081, 1'b0, 1'b1, 1'b1);
        wclk(40);
        chk("post-reset entry", last_pop[0], {2'b00, 9'h081});

        // 7O2 on the fractional-rate receiver: 0x5A has four ones, parity bit 1
        send(2, 9'h05A, 1'b0, 1'b1, 1'b1);
        wclk(300);
        chk("7O2 entry", last_pop[2], {2'b00, 9'h05A});
        send(2, 9'h05A, 1'b1, 1'b1, 1'b1);
        wclk(300);
        chk("7O2 parity error entry", last_pop[2], {2'b10, 9'h05A});

        // Randomised frames across all three receivers
        for (int k = 0; k < 24; k++) begin
            u = int'($urandom_range(0, 2));
            if (u != 2 && $urandom_range(0, 4) == 0) begin
                rx_l[u] = 1'b0;
                wclk(int'($urandom_range(1, 8)));
                rx_l[u] = 1'b1;
                wclk(60);
            end
            send(u, 9'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) != 0), 1'b1);
            wclk(int'($urandom_range(1, bclk(u))));
        end
        wclk(600);

        for (int i = 0; i < NU; i++) begin
            chk($sformatf("u%0d frames left unreceived", i), qsize(i), 0);
            chk($sformatf("u%0d overrun count", i), ovr_seen[i], exp_ovr[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
